branch_predictor_pht: RTL
=========================

// Module: branch_predictor_pht
// PURPOSE
//  Parametrised gshare branch direction predictor; successor to the single 2-bit history counter.
//  Holds a pattern history table (PHT) of saturating counters and a global history register (GHR).
//  IF stage does a combinational lookup by PC; the table is trained when the B-type resolves in EX.
//  Non-speculative: GHR and PHT change only on resolved branches, so no flush/repair path is needed.
// PARAMETERS
//  PC_W        32  width of fetch/EX program counters
//  PHT_ENTRIES 64  number of PHT counters; power of 2, >=4
//  CTR_W       2   saturating counter width, 2..4
//  GHR_W       6   global history bits; 1..$clog2(PHT_ENTRIES)
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-low reset
//  if_pc         in   PC_W    fetch PC to predict
//  pred_taken    out  1       prediction for if_pc (MSB of indexed counter)
//  pred_idx      out  IDX_W   PHT index used; pipelined to EX by the core (IDX_W=$clog2(PHT_ENTRIES))
//  ex_op         in   7       EX opcode; training only when ex_op == bp_pkg::OP_BTYPE
//  ex_idx        in   IDX_W   pred_idx carried with the EX-stage branch
//  actual_taken  in   1       resolved outcome from ALU
//  ghr_o         out  GHR_W   current global history (debug/trace)
// BEHAVIOUR
//  - Reset (rst=0, async): all counters = weakly-not-taken (2^(CTR_W-1)-1, i.e. 2'b01 at CTR_W=2);
//    GHR = 0; pred_taken reflects reset table (0); ghr_o = 0. Reset mid-operation discards all training.
//  - Index: idx = if_pc[IDX_W+1:2] ^ {{(IDX_W-GHR_W){1'b0}}, GHR}; PC bits [1:0] ignored.
//  - Lookup: purely combinational, zero latency; pred_taken = PHT[idx][CTR_W-1].
//  - Update (posedge, ex_op==OP_BTYPE only): PHT[ex_idx] +1 if actual_taken, -1 otherwise;
//    saturate at 2^CTR_W-1 and 0 (no wrap). GHR <= {GHR[GHR_W-2:0], actual_taken}.
//  - Non-branch ex_op: PHT and GHR hold; ex_idx/actual_taken ignored.
//  - Lookup and update to the same index in one cycle: lookup returns the pre-update value (no bypass);
//    new value visible from the next cycle. idx computed from pre-shift GHR that cycle.
//  - ex_idx is used verbatim; block does not recompute it from EX PC (keeps train index = predict index).
//  - Counter arithmetic at CTR_W bits; saturation compares against all-ones/zero, never overflows.
// CONFIGURATION
//  BP_GSHARE_EN defined: index XORs GHR as above (gshare).
//  BP_GSHARE_EN undefined: bimodal; idx = if_pc[IDX_W+1:2], GHR register and shift still present and
//    ghr_o still valid, but GHR never feeds the index. Counter training identical in both modes.
// STRUCTURE
//  bp_pkg: OP_BTYPE = 7'b1100011; ctr_init/ctr_max helper functions of CTR_W; IDX_W derivation.
//  Sub-module bp_sat_counter (CTR_W param; inc, dec, rst -> cnt): one instance per PHT entry via
//    generate; enable = (ex_op==OP_BTYPE && ex_idx==i). Top holds GHR, index hash, read mux.
//  PHT is a flop array (reset required); no SRAM macro.
// TESTING (defaults, BP_GSHARE_EN defined unless noted)
//  1 reset: rst=0 mid-run after training -> all pred_taken=0, ghr_o=0 at any if_pc; counters = 2'b01.
//  2 saturation up: 4 taken B-type at ex_idx=5 -> PHT[5]: 01->10->11->11->11; pred_taken=1 from 1st update.
//  3 saturation down: from 11, 4 not-taken at idx 5 -> 10,01,00,00; pred_taken=0 after 2nd update.
//  4 non-branch: ex_op=7'b0110011, actual_taken=1 for 10 cycles -> PHT and ghr_o unchanged.
//  5 GHR/hash: outcomes T,N,T -> ghr_o=6'b000101; if_pc=32'h40 -> pred_idx=16^5=21;
//    rebuild with BP_GSHARE_EN undefined -> pred_idx=16.
//  6 same-cycle hazard: if_pc maps to idx 3 while ex_idx=3 taken from 01 -> pred_taken=0 this cycle, 1 next.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and helpers for the gshare/bimodal branch predictor.
package bp_pkg;

  localparam logic [6:0] OP_BTYPE = 7'b1100011;

  // Weakly-not-taken: all ones except the MSB (2'b01 for a 2-bit counter).
  function automatic int ctr_init(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  function automatic int ctr_max(input int ctr_w);
    return (1 << ctr_w) - 1;
  endfunction

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter for one PHT entry; resets to weakly-not-taken.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] cnt
);

  localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(ctr_init(CTR_W));
  localparam logic [CTR_W-1:0] MAX_VAL  = CTR_W'(ctr_max(CTR_W));

  logic [CTR_W-1:0] cnt_reg;
  logic [CTR_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (inc && !dec && (cnt_reg != MAX_VAL)) begin
      cnt_next = cnt_reg + CTR_W'(1);
    end else if (dec && !inc && (cnt_reg != '0)) begin
      cnt_next = cnt_reg - CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= INIT_VAL;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/branch_predictor_pht.sv
// Non-speculative branch direction predictor: PHT of saturating counters plus GHR.
// Define BP_GSHARE_EN to XOR the GHR into the index (gshare); otherwise bimodal.
module branch_predictor_pht
  import bp_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int PHT_ENTRIES = 64,
  parameter int CTR_W       = 2,
  parameter int GHR_W       = 6,
  localparam int IDX_W      = idx_w(PHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic [6:0]       ex_op,
  input  logic [IDX_W-1:0] ex_idx,
  input  logic             actual_taken,
  output logic [GHR_W-1:0] ghr_o
);

  logic                   is_branch;
  logic [GHR_W-1:0]       ghr_reg;
  logic [GHR_W-1:0]       ghr_next;
  logic [IDX_W-1:0]       ghr_ext;
  logic [IDX_W-1:0]       pc_idx;
  logic [PHT_ENTRIES-1:0] train_en;
  logic [CTR_W-1:0]       pht_cnt [PHT_ENTRIES];
  logic                   unused_pc_bits;

  assign is_branch = (ex_op == OP_BTYPE);

  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign ghr_next = is_branch ? actual_taken : ghr_reg;
    end else begin : g_ghr_multi
      assign ghr_next = is_branch ? {ghr_reg[GHR_W-2:0], actual_taken} : ghr_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_reg <= '0;
    end else begin
      ghr_reg <= ghr_next;
    end
  end

  assign ghr_o   = ghr_reg;
  assign ghr_ext = IDX_W'(ghr_reg);
  assign pc_idx  = if_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

`ifdef BP_GSHARE_EN
  assign pred_idx = pc_idx ^ ghr_ext;
`else
  assign pred_idx = pc_idx;
`endif

  // Training uses ex_idx as carried from fetch, so predict and train always hit the same entry.
  generate
    for (genvar gi = 0; gi < PHT_ENTRIES; gi++) begin : g_pht
      assign train_en[gi] = is_branch && (ex_idx == IDX_W'(gi));

      bp_sat_counter #(
        .CTR_W(CTR_W)
      ) u_ctr (
        .clk(clk),
        .rst(rst),
        .inc(train_en[gi] & actual_taken),
        .dec(train_en[gi] & ~actual_taken),
        .cnt(pht_cnt[gi])
      );
    end
  endgenerate

  // Reads the registered counter, so a same-cycle update is seen only from the next cycle.
  assign pred_taken = pht_cnt[pred_idx][CTR_W-1];

endmodule
